alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries; power of two, 2..16.
REQ-002 Parameter TAG_W, default 4, width of the command/response tag.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  upstream command present.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_a / cmd_b  input  32 each  operands.
REQ-008 cmd_op  input  4  ALU opcode.
REQ-009 cmd_tag  input  TAG_W  opaque tag returned with the result.
REQ-010 alu_a / alu_b  output  32 each  registered operands to the combinational ALU.
REQ-011 alu_op  output  4  registered opcode to the ALU.
REQ-012 alu_result  input  32; alu_zero  input  1; alu_overflow  input  1  ALU outputs.
REQ-013 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-014 rsp_result  output  32; rsp_zero, rsp_overflow, rsp_illegal  output  1 each; rsp_tag  output  TAG_W.
REQ-015 busy  output  1  high when the FIFO is non-empty or the state is not IDLE.
REQ-016 cmd_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 A command transfers when cmd_valid and cmd_ready are high at a rising edge; cmd_ready SHALL equal NOT full (no same-cycle pass-through when full, even if a pop occurs).
REQ-018 Commands SHALL be stored in FIFO order; payload {a, b, op, tag}.
REQ-019 FSM states: IDLE, EXEC, HOLD.
REQ-020 IDLE: if the FIFO is non-empty, pop the head into the operand registers (alu_a, alu_b, alu_op, tag) and go to EXEC; otherwise stay in IDLE.
REQ-021 EXEC: capture alu_result, alu_zero, and alu_overflow into the response registers, set rsp_illegal = (op > 4'b0101), set rsp_valid, and go to HOLD.
REQ-022 HOLD: rsp_valid and all rsp_* outputs SHALL stay stable until rsp_ready is high; on that handshake, clear rsp_valid and then either pop the next head and go to EXEC if the FIFO is non-empty, or go to IDLE if it is empty.
REQ-023 Latency: a command accepted at edge N with the FIFO empty and the FSM in IDLE is popped at edge N+1, captured at edge N+2, and rsp_valid is high from cycle N+2 onward.
REQ-024 Peak throughput is one response per 2 cycles while rsp_ready is held high.
REQ-025 A simultaneous push and pop SHALL leave cmd_count unchanged and preserve order.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from the occupancy counter.
REQ-027 alu_a, alu_b, and alu_op SHALL hold their last popped values outside EXEC.
REQ-028 An illegal opcode SHALL still be executed and return the ALU output (result 0, zero 1), with rsp_illegal set.

Reset
REQ-029 While rst is high: FIFO emptied, cmd_count = 0, FSM = IDLE, rsp_valid = 0, and all rsp_* outputs, alu_a, alu_b, and alu_op = 0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight command and pending response without emitting a handshake.
REQ-031 cmd_ready SHALL be 0 while rst is high and DEPTH-ready (1) on the first cycle after rst deasserts.

Structure
REQ-032 Shared package alu_pkg SHALL hold the opcode constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5), OP_LAST=5, and the FSM state enum.
REQ-033 The FIFO SHALL be a single sub-module alu_cmd_fifo (parameters DEPTH and payload width, with push, pop, full, empty, and count); the FSM and response registers SHALL reside in the top module.
REQ-034 The ALU itself SHALL be instantiated outside this block; the testbench SHALL connect the team's 32-bit ALU.

Verification
REQ-035 Single ADD: a=5, b=7, op=0, tag=3, rsp_ready=1 -> rsp_valid at N+2 with result 12, zero=0, tag=3, then busy=0.
REQ-036 SUB to zero, then NOT: {9,9,op1} and {0,x,op5} back-to-back -> results 0 (zero=1) then 32'hFFFFFFFF (zero=0), in order, 2 cycles apart.
REQ-037 Backpressure/full: rsp_ready=0 while pushing 5 commands (DEPTH=4) -> cmd_ready falls after the FIFO holds 4; rsp outputs stay stable; releasing rsp_ready yields all 5 results in tag order.
REQ-038 Illegal op: op=4'hA, a=1, b=1 -> result 0, zero=1, rsp_illegal=1.
REQ-039 Reset mid-run: assert rst with 3 commands queued and rsp_valid=1 -> next cycle rsp_valid=0, cmd_count=0, and no response emitted for the flushed tags.
REQ-040 Wrap-around: 20 random commands under random rsp_ready -> every response matches the reference model, with pointers wrapping at least 4 times.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcode constants and FSM states.
// Imported by the sequencer top and anything else that decodes ALU opcodes.
package alu_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNot  = 4'd5;
  localparam logic [3:0] OpLast = 4'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StHold = 2'd2
  } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer: power-of-two depth, occupancy-counter based
// full/empty, head entry presented combinationally on rdata.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers are exactly log2(DEPTH) bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, feeds them one at a time to an external combinational ALU and
// returns each result with its tag over a valid/ready response port.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_a,
  input  logic [31:0]              cmd_b,
  input  logic [3:0]               cmd_op,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_op,
  input  logic [31:0]              alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_overflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_overflow,
  output logic                     rsp_illegal,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int unsigned PayloadW = 32 + 32 + 4 + TAG_W;

  state_e state_q, state_d;

  logic [PayloadW-1:0] head;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                rsp_load, rsp_clear;

  logic [31:0]      alu_a_q, alu_b_q;
  logic [3:0]       alu_op_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      rsp_result_q;
  logic             rsp_valid_q, rsp_zero_q, rsp_overflow_q, rsp_illegal_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // No pass-through when full, even if the head is popped this cycle.
  assign cmd_ready = !fifo_full && !rst;
  assign fifo_push = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PayloadW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({cmd_a, cmd_b, cmd_op, cmd_tag}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cmd_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    rsp_load  = 1'b0;
    rsp_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_load = 1'b1;
        state_d  = StHold;
      end
      StHold: begin
        if (rsp_ready) begin
          rsp_clear = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_op_q       <= '0;
      tag_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      rsp_tag_q      <= '0;
    end else begin
      if (fifo_pop) begin
        {alu_a_q, alu_b_q, alu_op_q, tag_q} <= head;
      end
      if (rsp_load) begin
        rsp_valid_q    <= 1'b1;
        rsp_result_q   <= alu_result;
        rsp_zero_q     <= alu_zero;
        rsp_overflow_q <= alu_overflow;
        rsp_illegal_q  <= (alu_op_q > OpLast);
        rsp_tag_q      <= tag_q;
      end else if (rsp_clear) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_illegal  = rsp_illegal_q;
  assign rsp_tag      = rsp_tag_q;
  assign busy         = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed vectors push expected responses,
// a negedge monitor pops and compares each response handshake.
module tb_alu_cmd_sequencer;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_op, cmd_tag;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_overflow, rsp_illegal;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        busy;
  logic [2:0]  cmd_count;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   hs_cnt = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   prev_hs = 0;
  logic rand_done;

  alu_cmd_sequencer #(
    .DEPTH (4),
    .TAG_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .cmd_op       (cmd_op),
    .cmd_tag      (cmd_tag),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_illegal  (rsp_illegal),
    .rsp_tag      (rsp_tag),
    .busy         (busy),
    .cmd_count    (cmd_count)
  );

  // Team 32-bit ALU model: {overflow, zero, result}.
  function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [31:0] r;
    logic        o;
    o = 1'b0;
    case (op)
      4'd0: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      default: r = 32'd0;
    endcase
    return {o, (r == 32'd0), r};
  endfunction

  always_comb {alu_overflow, alu_zero, alu_result} = ref_alu(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: a response transfers at the posedge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {60'd0, rsp_tag}, 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
        chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, e.z});
        chk("rsp_overflow", {63'd0, rsp_overflow}, {63'd0, e.o});
        chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e.ill});
        chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
      end
      hs_cnt  = hs_cnt + 1;
      prev_hs = last_hs;
      last_hs = cyc;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [3:0] tag, input logic [31:0] res, input logic z,
                      input logic o, input logic ill);
    logic acc;
    int   n;
    exp_q.push_back('{res: res, z: z, o: o, ill: ill, tag: tag});
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    n = 0;
    do begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs_before;
    logic [31:0] held_res;
    logic [3:0]  held_tag;

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    rand_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    chk("reset_cmd_count", {61'd0, cmd_count}, 64'd0);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_alu", {alu_a, alu_b[27:0], alu_op}, 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // Single ADD with latency check.
    rsp_ready = 1'b1;
    send(32'd5, 32'd7, 4'd0, 4'd3, 32'd12, 1'b0, 1'b0, 1'b0);
    chk("lat_n0_valid", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_n1_valid", {63'd0, rsp_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_n2_valid", {63'd0, rsp_valid}, 64'd1);
    @(posedge clk); #1;
    chk("single_busy_after", {63'd0, busy}, 64'd0);

    // SUB to zero then NOT back-to-back: responses two cycles apart.
    send(32'd9, 32'd9, 4'd1, 4'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    send(32'd0, 32'h1234, 4'd5, 4'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    drain();
    chk("b2b_spacing", 64'(last_hs - prev_hs), 64'd2);

    // Signed overflow on ADD.
    send(32'h7FFF_FFFF, 32'd1, 4'd0, 4'd4, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    drain();

    // Backpressure: 5 commands, one in flight and four queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(32'(i + 1), 32'd10, 4'd0, 4'(i), 32'(i + 11), 1'b0, 1'b0, 1'b0);
    end
    chk("full_count", {61'd0, cmd_count}, 64'd4);
    chk("full_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    held_res = rsp_result;
    held_tag = rsp_tag;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
    chk("hold_result", {32'd0, rsp_result}, {32'd0, held_res});
    chk("hold_result_value", {32'd0, rsp_result}, 64'd11);
    chk("hold_tag", {60'd0, rsp_tag}, {60'd0, held_tag});
    rsp_ready = 1'b1;
    drain();

    // Illegal opcode still executes the ALU and flags the response.
    send(32'd1, 32'd1, 4'hA, 4'd9, 32'd0, 1'b1, 1'b0, 1'b1);
    drain();

    // Reset mid-run with three queued commands and a pending response.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'd100, 32'(i), 4'd0, 4'(i + 5), 32'(100 + i), 1'b0, 1'b0, 1'b0);
    end
    chk("flush_pre_count", {61'd0, cmd_count}, 64'd3);
    chk("flush_pre_valid", {63'd0, rsp_valid}, 64'd1);
    hs_before = hs_cnt;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("flush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("flush_cmd_count", {61'd0, cmd_count}, 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_no_rsp", 64'(hs_cnt), 64'(hs_before));
    chk("flush_busy", {63'd0, busy}, 64'd0);

    // Random traffic under random backpressure; 20 pushes wrap DEPTH=4 pointers 5 times.
    hs_before = hs_cnt;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [31:0] ra, rb;
          logic [3:0]  rop;
          logic [33:0] r;
          ra  = $urandom();
          rb  = (i % 5 == 0) ? ra : $urandom();
          rop = 4'($urandom_range(0, 7));
          r   = ref_alu(ra, rb, rop);
          send(ra, rb, rop, 4'(i), r[31:0], r[32], r[33], (rop > 4'd5));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    chk("rand_rsp_count", 64'(hs_cnt - hs_before), 64'd20);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
